// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with control decode and 2-entry skid buffer (optional stats: ALU_ISSUE_STATS_EN)
module alu_issue_stage #(
  parameter int DATA_W = 64
`ifdef ALU_ISSUE_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic [1:0]        alu_op_class,
  input  logic [2:0]        funct3,
  input  logic              funct7_b5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  output logic              illegal
`ifdef ALU_ISSUE_STATS_EN
  , output logic [CNT_W-1:0] issue_cnt
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] illegal_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLL = 4'b1000;

  state_t state;

  logic [DATA_W-1:0] skid_a;
  logic [DATA_W-1:0] skid_b;
  logic [3:0]        skid_ctrl;
  logic              skid_illegal;

  logic [DATA_W-1:0] new_b;
  logic [3:0]        new_ctrl;
  logic              new_illegal;
  logic              accept;
  logic              consume;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;
  assign new_b   = alu_src ? imm : rs2_data;

  // Decode op class / funct fields into the ALU control code and illegal flag
  always_comb begin
    new_ctrl    = CTRL_ADD;
    new_illegal = 1'b0;
    case (alu_op_class)
      2'b00: new_ctrl = CTRL_ADD;
      2'b01: new_ctrl = CTRL_SUB;
      2'b10: begin
        case ({funct7_b5, funct3})
          4'b0_000:         new_ctrl = CTRL_ADD;
          4'b1_000:         new_ctrl = CTRL_SUB;
          4'b0_111, 4'b1_111: new_ctrl = CTRL_AND;
          4'b0_110, 4'b1_110: new_ctrl = CTRL_OR;
          4'b0_001:         new_ctrl = CTRL_SLL;
          default:          new_illegal = 1'b1;
        endcase
      end
      default: new_illegal = 1'b1;
    endcase
  end

  // Buffer FSM: main entry drives the ALU outputs, skid catches the second entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= CTRL_ADD;
      illegal      <= 1'b0;
      skid_a       <= '0;
      skid_b       <= '0;
      skid_ctrl    <= CTRL_ADD;
      skid_illegal <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            alu_a     <= rs1_data;
            alu_b     <= new_b;
            alu_ctrl  <= new_ctrl;
            illegal   <= new_illegal;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            skid_a       <= rs1_data;
            skid_b       <= new_b;
            skid_ctrl    <= new_ctrl;
            skid_illegal <= new_illegal;
            in_ready     <= 1'b0;
            state        <= TWO;
          end else if (accept && consume) begin
            alu_a    <= rs1_data;
            alu_b    <= new_b;
            alu_ctrl <= new_ctrl;
            illegal  <= new_illegal;
          end else if (consume) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            alu_a    <= skid_a;
            alu_b    <= skid_b;
            alu_ctrl <= skid_ctrl;
            illegal  <= skid_illegal;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Statistics counters; they wrap naturally at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt   <= '0;
      stall_cnt   <= '0;
      illegal_cnt <= '0;
    end else begin
      if (consume) issue_cnt <= issue_cnt + 1'b1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 1'b1;
      if (consume && illegal) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized and directed bench for alu_issue_stage against a queue model
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] rs1_data, rs2_data, imm;
  logic        alu_src;
  logic [1:0]  alu_op_class;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic        illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_cnt, stall_cnt, illegal_cnt;
`endif

  alu_issue_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_src(alu_src), .alu_op_class(alu_op_class),
    .funct3(funct3), .funct7_b5(funct7_b5),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .illegal(illegal)
`ifdef ALU_ISSUE_STATS_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  c;
    logic        il;
  } txn_t;

  txn_t q[$];
  int checks = 0;
  int failures = 0;
  int xfers = 0;
  longint m_issue = 0, m_stall = 0, m_ill = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t expect_txn();
    txn_t t;
    t.a  = rs1_data;
    t.b  = alu_src ? imm : rs2_data;
    t.c  = 4'd2;
    t.il = 1'b0;
    if (alu_op_class == 2'd1) t.c = 4'd6;
    else if (alu_op_class == 2'd3) t.il = 1'b1;
    else if (alu_op_class == 2'd2) begin
      if (funct3 == 3'd7) t.c = 4'd0;
      else if (funct3 == 3'd6) t.c = 4'd1;
      else if (funct3 == 3'd0) t.c = funct7_b5 ? 4'd6 : 4'd2;
      else if (funct3 == 3'd1 && !funct7_b5) t.c = 4'd8;
      else t.il = 1'b1;
    end
    return t;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk({tag, ".alu_a"}, alu_a, q[0].a);
      chk({tag, ".alu_b"}, alu_b, q[0].b);
      chk({tag, ".alu_ctrl"}, {60'd0, alu_ctrl}, {60'd0, q[0].c});
      chk({tag, ".illegal"}, {63'd0, illegal}, {63'd0, q[0].il});
    end
`ifdef ALU_ISSUE_STATS_EN
    chk({tag, ".issue_cnt"}, {32'd0, issue_cnt}, m_issue & 64'hFFFF_FFFF);
    chk({tag, ".stall_cnt"}, {32'd0, stall_cnt}, m_stall & 64'hFFFF_FFFF);
    chk({tag, ".illegal_cnt"}, {32'd0, illegal_cnt}, m_ill & 64'hFFFF_FFFF);
`endif
  endtask

  // One clock: decide transfers from the model, advance, then compare
  task automatic cycle(input string tag);
    txn_t t;
    bit acc, con;
    t   = expect_txn();
    acc = in_valid && (q.size() < 2);
    con = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready) m_stall++;
    if (con) begin
      m_issue++;
      if (q[0].il) m_ill++;
    end
    @(posedge clk);
    #1;
    if (con) begin
      void'(q.pop_front());
      xfers++;
    end
    if (acc) q.push_back(t);
    check_outputs(tag);
  endtask

  task automatic set_in(input logic [1:0] cls, input logic f7, input logic [2:0] f3,
                        input logic [63:0] r1, input logic [63:0] r2,
                        input logic [63:0] im, input logic src);
    alu_op_class = cls; funct7_b5 = f7; funct3 = f3;
    rs1_data = r1; rs2_data = r2; imm = im; alu_src = src;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("drain");
  endtask

  initial begin
    int x0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(2'd2, 1'b0, 3'd0, 64'd5, 64'd3, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_outputs("reset");
    chk("reset.alu_a", alu_a, 64'd0);
    chk("reset.alu_b", alu_b, 64'd0);
    chk("reset.alu_ctrl", {60'd0, alu_ctrl}, 64'd2);
    chk("reset.illegal", {63'd0, illegal}, 64'd0);

    // directed decode cases
    in_valid = 1'b1;
    cycle("add");
    chk("add.ctrl_direct", {60'd0, alu_ctrl}, 64'd2);
    chk("add.b_direct", alu_b, 64'd3);
    set_in(2'd2, 1'b1, 3'd0, 64'd9, 64'd4, 64'd0, 1'b0); cycle("sub");
    chk("sub.ctrl_direct", {60'd0, alu_ctrl}, 64'd6);
    set_in(2'd2, 1'b0, 3'd7, 64'd1, 64'd2, 64'd0, 1'b0); cycle("and");
    set_in(2'd2, 1'b1, 3'd6, 64'd1, 64'd2, 64'd0, 1'b0); cycle("or");
    set_in(2'd2, 1'b0, 3'd1, 64'd1, 64'd2, 64'd0, 1'b0); cycle("sll");
    chk("sll.ctrl_direct", {60'd0, alu_ctrl}, 64'd8);
    set_in(2'd2, 1'b0, 3'd2, 64'd1, 64'd2, 64'd0, 1'b0); cycle("ill_f3");
    chk("ill.flag_direct", {63'd0, illegal}, 64'd1);
    set_in(2'd2, 1'b1, 3'd1, 64'd1, 64'd2, 64'd0, 1'b0); cycle("ill_sll");
    set_in(2'd3, 1'b0, 3'd0, 64'd1, 64'd2, 64'd0, 1'b0); cycle("ill_cls");
    set_in(2'd1, 1'b0, 3'd0, 64'd1, 64'd2, 64'd0, 1'b0); cycle("branch");
    set_in(2'd0, 1'b0, 3'd0, 64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1); cycle("imm");
    chk("imm.b_direct", alu_b, 64'hFFFF_FFFF_FFFF_FFF8);
    drain();

    // backpressure: two entries held, then released in order
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(2'd2, 1'b0, 3'd0, 64'hA, 64'h1, 64'd0, 1'b0); cycle("bp_A");
    set_in(2'd2, 1'b1, 3'd0, 64'hB, 64'h2, 64'd0, 1'b0); cycle("bp_B");
    chk("bp.in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp.hold_A", alu_a, 64'hA);
    in_valid = 1'b0;
    cycle("bp_hold");
    out_ready = 1'b1;
    cycle("bp_outA");
    chk("bp.second_B", alu_a, 64'hB);
    chk("bp.in_ready_back", {63'd0, in_ready}, 64'd1);
    cycle("bp_outB");
    drain();

    // full-rate streaming
    x0 = xfers;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(2'd2, 1'b0, 3'd0, 64'(100 + i), 64'(i), 64'd0, 1'b0);
      cycle("stream");
    end
    in_valid = 1'b0;
    cycle("stream_tail");
    chk("stream.count", 64'(xfers - x0), 64'd10);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      set_in(2'($urandom), 1'($urandom), 3'($urandom), {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      cycle("rand");
    end
    drain();

    // asynchronous reset while holding two entries
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(2'd0, 1'b0, 3'd0, 64'd11, 64'd12, 64'd0, 1'b0); cycle("rst_fill1");
    set_in(2'd3, 1'b0, 3'd0, 64'd13, 64'd14, 64'd0, 1'b0); cycle("rst_fill2");
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    q.delete();
    m_issue = 0; m_stall = 0; m_ill = 0;
    chk("rst_mid.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid.in_ready", {63'd0, in_ready}, 64'd1);
    check_outputs("rst_mid");
    reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    set_in(2'd2, 1'b0, 3'd0, 64'd21, 64'd22, 64'd0, 1'b0); cycle("post_rst1");
    set_in(2'd2, 1'b0, 3'd0, 64'd23, 64'd24, 64'd0, 1'b0); cycle("post_rst2");
    drain();
`ifdef ALU_ISSUE_STATS_EN
    chk("post_rst.issue_cnt", {32'd0, issue_cnt}, 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
